i2s_tx_multi: RTL and testbench
===============================

// Module: i2s_tx_multi
// PURPOSE
//  Parametrised audio serial transmitter. Successor to the fixed 16-bit stereo i2s block.
//  Runs on the codec master clock, derives SCLK/LRCLK, pops one sample per channel slot from the audio FIFO and
//  shifts it MSB-first to the codec DIN pin.
//  Adds channel count (stereo or TDM), Philips I2S / left-justified framing, selectable underrun policy, start/stop control and underrun accounting.
// PARAMETERS
//  WIDTH      16  sample width in bits (AUDIO port width)
//  SLOT_BITS  32  SCLK periods per channel slot; must be >= WIDTH+1
//  CHANNELS   2   slots per frame; 2 = stereo LRCLK, >2 = TDM frame-sync pulse
//  MCLK_DIV   4   CLK cycles per SCLK period; even, >= 4
//  MODE       0   0 = I2S (MSB one SCLK after slot start), 1 = left-justified (MSB at slot start)
//  HOLD_LAST  0   0 = send zero on underrun, 1 = repeat last sample of that channel
// PORTS
//  CLK          in   1      master clock (MCLK); all logic on rising edge
//  RESET        in   1      synchronous, active-high
//  ENABLE       in   1      run request, sampled only at frame boundaries
//  AUDIO        in   WIDTH  FIFO read data, valid the CLK after FIFO_READ
//  FIFO_EMPTY   in   1      FIFO has no sample
//  FIFO_READ    out  1      one-CLK pop strobe
//  SCLK         out  1      bit clock
//  LRCLK        out  1      word select (stereo) / frame sync (TDM)
//  DIN          out  1      serial data to codec
//  UNDERRUN     out  1      one-CLK pulse per slot sent without a fresh sample
//  UNDERRUN_CNT out  16     saturating underrun count
// BEHAVIOUR
//  - Reset values: SCLK=0, LRCLK=0, DIN=0, FIFO_READ=0, UNDERRUN=0, UNDERRUN_CNT=0.
//    Counters are zero. Hold registers are zero. State is IDLE.
//  - Reset asserted mid-frame aborts at once. No partial FIFO pop is left pending.
//  - Counters:
//    - div_cnt counts 0..MCLK_DIV-1.
//    - bit_cnt counts 0..SLOT_BITS-1 and advances when div_cnt wraps.
//    - slot counts 0..CHANNELS-1 and advances when bit_cnt wraps.
//  - SCLK = (div_cnt >= MCLK_DIV/2). DIN changes only at div_cnt==0 (SCLK falling), so it is stable at the rising edge.
//  - States:
//    - IDLE: counters held at 0; SCLK, LRCLK and DIN low.
//    - RUN: free-running.
//    - IDLE->RUN on the first CLK with ENABLE=1; div_cnt=0, bit_cnt=0, slot=0 on the next CLK.
//    - RUN->IDLE only at the end of slot CHANNELS-1, bit SLOT_BITS-1, div_cnt MCLK_DIV-1 with ENABLE=0.
//    - Deasserting ENABLE mid-frame therefore completes the frame.
//  - LRCLK:
//    - CHANNELS==2: LRCLK=0 in slot 0 (left), 1 in slot 1 (right).
//    - CHANNELS>2: LRCLK=1 for bit_cnt==0 of slot 0 only (one SCLK period), else 0.
//  - Data placement, with off = (MODE==0) ? 1 : 0:
//    - MSB on DIN at bit_cnt==off; LSB at bit_cnt==off+WIDTH-1.
//    - DIN=0 for all other bits, including bit 0 in MODE 0.
//  - Fetch:
//    - At div_cnt==0 of bit_cnt==SLOT_BITS-2 of the preceding slot (cyclic: slot CHANNELS-1 precedes slot 0), sample FIFO_EMPTY.
//    - If 0: FIFO_READ=1 for that CLK. AUDIO is captured next CLK into the next-slot holding register and into the per-channel last[slot] register.
//    - If 1: no pop. Holding register = HOLD_LAST ? last[slot] : 0. UNDERRUN pulses one CLK. UNDERRUN_CNT increments, saturating at 16'hFFFF.
//    - The holding register loads the shift register at the slot's bit_cnt==0 boundary.
//  - First frame after IDLE: the slot-0 fetch occurs at the IDLE->RUN transition CLK, so slot 0 is always fed.
//  - FIFO order is channel 0 first. In stereo, channel 0 = left.
//  - No pop ever occurs in IDLE or RESET.
//  - Frame length = CHANNELS*SLOT_BITS*MCLK_DIV CLK.
//  - Bench reference: defaults give a 256-CLK frame and 2 pops per frame.
// TESTING
//  1. Defaults. FIFO holds 0x8001, 0x7FFE; ENABLE=1.
//     -> LRCLK low for 128 CLK, then high for 128 CLK.
//     -> Left bits 1..16 = 1000_0000_0000_0001; right = 0111_1111_1111_1110; other bits 0.
//     -> Exactly 2 FIFO_READ pulses per frame.
//  2. MODE=1, same data.
//     -> MSB at bit 0 coincident with the LRCLK edge; bits 16..31 = 0.
//  3. Empty FIFO, HOLD_LAST=0.
//     -> DIN=0 throughout; 2 UNDERRUN pulses per frame; UNDERRUN_CNT=6 after 3 frames.
//     -> FIFO_READ never asserted.
//     HOLD_LAST=1: after one frame of 0x1234/0x5678, the FIFO runs empty -> the same words repeat.
//  4. CHANNELS=4, SLOT_BITS=32. Push 0xAAAA, 0x5555, 0xFFFF, 0x0001.
//     -> LRCLK high for 4 CLK every 512 CLK.
//     -> Slots carry the words in order; 4 pops per frame.
//  5. Drop ENABLE at slot 0 bit 10.
//     -> Right slot completes; SCLK, LRCLK and DIN held low afterwards; no further pops.
//     Raise ENABLE -> new frame begins at slot 0.
//  6. Assert RESET at slot 1 bit 5 with a pending fetch.
//     -> All outputs go to zero the next CLK; no FIFO_READ pulse.
//     -> After release, the first frame starts cleanly and UNDERRUN_CNT=0.

Source files
------------

// File: rtl/i2s_tx_multi.sv
// rtl/i2s_tx_multi.sv - parametrised I2S / left-justified / TDM audio serial transmitter
// Derives SCLK/LRCLK from MCLK, prefetches one FIFO sample per slot and shifts it MSB-first onto DIN.
module i2s_tx_multi #(
   parameter int WIDTH     = 16,
   parameter int SLOT_BITS = 32,
   parameter int CHANNELS  = 2,
   parameter int MCLK_DIV  = 4,
   parameter int MODE      = 0,
   parameter int HOLD_LAST = 0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic [WIDTH-1:0] AUDIO,
   input  logic             FIFO_EMPTY,
   output logic             FIFO_READ,
   output logic             SCLK,
   output logic             LRCLK,
   output logic             DIN,
   output logic             UNDERRUN,
   output logic [15:0]      UNDERRUN_CNT
);

   localparam int DW  = $clog2(MCLK_DIV);
   localparam int BW  = $clog2(SLOT_BITS);
   localparam int SW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int OFF = (MODE == 0) ? 1 : 0;

   localparam logic [0:0]    ST_IDLE   = 1'b0;
   localparam logic [0:0]    ST_RUN    = 1'b1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(MCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF  = DW'(MCLK_DIV / 2);
   localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
   localparam logic [BW-1:0] BIT_FETCH = BW'(SLOT_BITS - 2);
   localparam logic [SW-1:0] SLOT_LAST = SW'(CHANNELS - 1);

   logic [0:0]       state;
   logic [DW-1:0]    div_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [SW-1:0]    slot;
   logic [WIDTH-1:0] cur_word;
   logic [WIDTH-1:0] nxt_word;
   logic [WIDTH-1:0] last_word [CHANNELS];
   logic             cap_pend;
   logic             cap_first;
   logic [SW-1:0]    cap_slot;
   logic             wrap_skip;

   logic             run;
   logic             div_wrap;
   logic             bit_wrap;
   logic             frame_end;
   logic             fetch_pt;
   logic             wrap_fetch;
   logic             start;
   logic             fetch;
   logic [SW-1:0]    next_slot;
   logic [SW-1:0]    fetch_slot;
   logic [WIDTH-1:0] hold_val;
   logic [WIDTH-1:0] word_now;
   logic             lr_nxt;
   logic             din_nxt;
   int               bit_pos;

   assign run        = (state == ST_RUN);
   assign div_wrap   = (div_cnt == DIV_LAST);
   assign bit_wrap   = (bit_cnt == BIT_LAST);
   assign frame_end  = run && div_wrap && bit_wrap && (slot == SLOT_LAST);
   assign fetch_pt   = run && (div_cnt == '0) && (bit_cnt == BIT_FETCH);
   assign wrap_fetch = fetch_pt && (slot == SLOT_LAST);
   assign start      = !run && ENABLE;
   // A frame-wrap fetch is skipped once ENABLE drops so no sample is popped for a frame that will not run.
   assign fetch      = start || (fetch_pt && (!wrap_fetch || ENABLE));
   assign next_slot  = (slot == SLOT_LAST) ? '0 : slot + SW'(1);
   assign fetch_slot = start ? '0 : next_slot;
   assign hold_val   = (HOLD_LAST != 0) ? last_word[fetch_slot] : '0;
   assign FIFO_READ  = !RESET && fetch && !FIFO_EMPTY;
   // The first slot after IDLE is served straight from AUDIO while it is being captured.
   assign word_now   = (cap_pend && cap_first) ? AUDIO : cur_word;
   assign lr_nxt     = run && ((CHANNELS == 2) ? (slot == SW'(1))
                                               : ((slot == '0) && (bit_cnt == '0)));

   always_comb begin
      din_nxt = 1'b0;
      bit_pos = int'(bit_cnt) - OFF;
      if (bit_pos >= 0 && bit_pos < WIDTH)
         din_nxt = word_now[IW'(WIDTH - 1 - bit_pos)];
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= ST_IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         slot         <= '0;
         cur_word     <= '0;
         nxt_word     <= '0;
         for (int c = 0; c < CHANNELS; c++) last_word[c] <= '0;
         cap_pend     <= 1'b0;
         cap_first    <= 1'b0;
         cap_slot     <= '0;
         wrap_skip    <= 1'b0;
         SCLK         <= 1'b0;
         LRCLK        <= 1'b0;
         DIN          <= 1'b0;
         UNDERRUN     <= 1'b0;
         UNDERRUN_CNT <= '0;
      end else begin
         cap_pend  <= FIFO_READ;
         cap_first <= start;
         cap_slot  <= fetch_slot;
         UNDERRUN  <= fetch && FIFO_EMPTY;

         if (cap_pend) begin
            last_word[cap_slot] <= AUDIO;
            if (cap_first) cur_word <= AUDIO;
            else           nxt_word <= AUDIO;
         end
         if (fetch && FIFO_EMPTY) begin
            if (start) cur_word <= hold_val;
            else       nxt_word <= hold_val;
            if (UNDERRUN_CNT != '1) UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
         end
         if (wrap_fetch && !ENABLE) wrap_skip <= 1'b1;

         SCLK  <= run && (div_cnt >= DIV_HALF);
         LRCLK <= lr_nxt;
         if (!run)                DIN <= 1'b0;
         else if (div_cnt == '0)  DIN <= din_nxt;

         if (!run) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            slot      <= '0;
            wrap_skip <= 1'b0;
            if (ENABLE) state <= ST_RUN;
         end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap) begin
               bit_cnt <= bit_wrap ? '0 : bit_cnt + BW'(1);
               if (bit_wrap) begin
                  slot     <= next_slot;
                  cur_word <= nxt_word;
               end
            end
            // A skipped wrap fetch forces a pass through IDLE so the restart refetches slot 0.
            if (frame_end && (!ENABLE || wrap_skip)) begin
               state     <= ST_IDLE;
               wrap_skip <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_multi.sv
// tb/tb_i2s_tx_multi.sv - directed bench for i2s_tx_multi in stereo I2S, left-justified hold-last and TDM builds
module tb_i2s_tx_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  en;
   logic [2:0]  sclk, lrclk, din, fifo_read, fifo_empty, underrun;
   logic [15:0] audio [3];
   logic [15:0] ucnt  [3];
   logic [15:0] mem   [3][32];
   int          wr [3];
   int          rd [3];

   int          n_cmp = 0;
   int          n_err = 0;

   int          rdc [3], urc [3], nb [3], idle [3], nlog [3];
   int          lr_run [3], hi_len [3], lo_len [3];
   logic [31:0] sh [3];
   logic [31:0] wlog [3][32];
   logic [2:0]  sclk_prev = '0;
   logic [2:0]  lr_prev = '0;

   always #5 clk = ~clk;

   assign fifo_empty[0] = (rd[0] == wr[0]);
   assign fifo_empty[1] = (rd[1] == wr[1]);
   assign fifo_empty[2] = (rd[2] == wr[2]);

   i2s_tx_multi u_std (
      .CLK(clk), .RESET(rst), .ENABLE(en[0]), .AUDIO(audio[0]), .FIFO_EMPTY(fifo_empty[0]),
      .FIFO_READ(fifo_read[0]), .SCLK(sclk[0]), .LRCLK(lrclk[0]), .DIN(din[0]),
      .UNDERRUN(underrun[0]), .UNDERRUN_CNT(ucnt[0]));

   i2s_tx_multi #(.MODE(1), .HOLD_LAST(1)) u_lj (
      .CLK(clk), .RESET(rst), .ENABLE(en[1]), .AUDIO(audio[1]), .FIFO_EMPTY(fifo_empty[1]),
      .FIFO_READ(fifo_read[1]), .SCLK(sclk[1]), .LRCLK(lrclk[1]), .DIN(din[1]),
      .UNDERRUN(underrun[1]), .UNDERRUN_CNT(ucnt[1]));

   i2s_tx_multi #(.CHANNELS(4)) u_tdm (
      .CLK(clk), .RESET(rst), .ENABLE(en[2]), .AUDIO(audio[2]), .FIFO_EMPTY(fifo_empty[2]),
      .FIFO_READ(fifo_read[2]), .SCLK(sclk[2]), .LRCLK(lrclk[2]), .DIN(din[2]),
      .UNDERRUN(underrun[2]), .UNDERRUN_CNT(ucnt[2]));

   // FIFO models: data appears on AUDIO the CLK after the pop strobe
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (fifo_read[i]) begin
            audio[i] <= mem[i][rd[i]];
            rd[i]    <= rd[i] + 1;
         end
      end
   end

   // Codec-side monitor: assembles 32-bit slots from DIN at SCLK rising, tracks LRCLK run lengths
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         rdc[i] <= rdc[i] + (fifo_read[i] ? 1 : 0);
         urc[i] <= urc[i] + (underrun[i] ? 1 : 0);
         if (sclk[i]) begin
            idle[i] <= 0;
            if (!sclk_prev[i]) begin
               sh[i] <= {sh[i][30:0], din[i]};
               if (nb[i] % 32 == 31) begin
                  wlog[i][nlog[i]] <= {sh[i][30:0], din[i]};
                  nlog[i]          <= nlog[i] + 1;
               end
               nb[i] <= nb[i] + 1;
            end
         end else begin
            idle[i] <= idle[i] + 1;
            if (idle[i] > 8) nb[i] <= 0;
         end
         if (lrclk[i] != lr_prev[i]) begin
            if (lr_prev[i]) hi_len[i] <= lr_run[i];
            else            lo_len[i] <= lr_run[i];
            lr_run[i] <= 1;
         end else begin
            lr_run[i] <= lr_run[i] + 1;
         end
      end
      sclk_prev <= sclk;
      lr_prev   <= lrclk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input int i, input logic [15:0] d);
      mem[i][wr[i]] = d;
      wr[i] = wr[i] + 1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_frames(input int i, input int on_cycles, input int total);
      en[i] = 1'b1;
      cycles(on_cycles);
      en[i] = 1'b0;
      cycles(total - on_cycles);
   endtask

   task automatic check_idle(input int i, input string tag);
      check_eq({tag, "_sclk"},  32'(sclk[i]),  32'd0);
      check_eq({tag, "_lrclk"}, 32'(lrclk[i]), 32'd0);
      check_eq({tag, "_din"},   32'(din[i]),   32'd0);
   endtask

   int b, p, u;

   initial begin
      rst = 1'b1;
      en  = '0;
      cycles(4);
      check_idle(0, "rst");
      check_eq("rst_fifo_read", 32'(fifo_read[0]), 32'd0);
      check_eq("rst_underrun",  32'(underrun[0]),  32'd0);
      check_eq("rst_ucnt",      32'(ucnt[0]),      32'd0);
      rst = 1'b0;
      cycles(20);

      // stereo I2S, two frames of 0x8001/0x7FFE
      b = nlog[0]; p = rdc[0];
      push(0, 16'h8001); push(0, 16'h7FFE); push(0, 16'h8001); push(0, 16'h7FFE);
      run_frames(0, 300, 650);
      check_eq("i2s_slots",   32'(nlog[0] - b), 32'd4);
      check_eq("i2s_left0",   wlog[0][b],       32'h4000_8000);
      check_eq("i2s_right0",  wlog[0][b+1],     32'h3FFF_0000);
      check_eq("i2s_left1",   wlog[0][b+2],     32'h4000_8000);
      check_eq("i2s_right1",  wlog[0][b+3],     32'h3FFF_0000);
      check_eq("i2s_pops",    32'(rdc[0] - p),  32'd4);
      check_eq("i2s_ucnt",    32'(ucnt[0]),     32'd0);
      check_eq("i2s_lr_high", 32'(hi_len[0]),   32'd128);
      check_eq("i2s_lr_low",  32'(lo_len[0]),   32'd128);
      check_idle(0, "i2s_stop");

      // left-justified: MSB at slot start, low half zero
      b = nlog[1]; p = rdc[1];
      push(1, 16'h8001); push(1, 16'h7FFE);
      run_frames(1, 100, 400);
      check_eq("lj_left",    wlog[1][b],      32'h8001_0000);
      check_eq("lj_right",   wlog[1][b+1],    32'h7FFE_0000);
      check_eq("lj_pops",    32'(rdc[1] - p), 32'd2);
      check_eq("lj_lr_high", 32'(hi_len[1]),  32'd128);

      // hold-last: second frame repeats the first after the FIFO runs dry
      b = nlog[1]; p = rdc[1]; u = urc[1];
      push(1, 16'h1234); push(1, 16'h5678);
      run_frames(1, 300, 650);
      check_eq("hold_slots",  32'(nlog[1] - b), 32'd4);
      check_eq("hold_l0",     wlog[1][b],       32'h1234_0000);
      check_eq("hold_r0",     wlog[1][b+1],     32'h5678_0000);
      check_eq("hold_l1",     wlog[1][b+2],     32'h1234_0000);
      check_eq("hold_r1",     wlog[1][b+3],     32'h5678_0000);
      check_eq("hold_pops",   32'(rdc[1] - p),  32'd2);
      check_eq("hold_pulses", 32'(urc[1] - u),  32'd2);
      check_eq("hold_ucnt",   32'(ucnt[1]),     32'd2);

      // empty FIFO, zero fill, three frames
      b = nlog[0]; p = rdc[0]; u = urc[0];
      run_frames(0, 600, 900);
      check_eq("empty_slots",  32'(nlog[0] - b), 32'd6);
      for (int k = 0; k < 6; k++) check_eq("empty_word", wlog[0][b+k], 32'd0);
      check_eq("empty_pulses", 32'(urc[0] - u),  32'd6);
      check_eq("empty_ucnt",   32'(ucnt[0]),     32'd6);
      check_eq("empty_pops",   32'(rdc[0] - p),  32'd0);

      // TDM, four channels, two frames
      b = nlog[2]; p = rdc[2];
      for (int k = 0; k < 2; k++) begin
         push(2, 16'hAAAA); push(2, 16'h5555); push(2, 16'hFFFF); push(2, 16'h0001);
      end
      run_frames(2, 600, 1200);
      check_eq("tdm_slots",   32'(nlog[2] - b), 32'd8);
      check_eq("tdm_s0",      wlog[2][b],       32'h5555_0000);
      check_eq("tdm_s1",      wlog[2][b+1],     32'h2AAA_8000);
      check_eq("tdm_s2",      wlog[2][b+2],     32'h7FFF_8000);
      check_eq("tdm_s3",      wlog[2][b+3],     32'h0000_8000);
      check_eq("tdm_s4",      wlog[2][b+4],     32'h5555_0000);
      check_eq("tdm_pops",    32'(rdc[2] - p),  32'd8);
      check_eq("tdm_fs_high", 32'(hi_len[2]),   32'd4);
      check_eq("tdm_fs_low",  32'(lo_len[2]),   32'd508);

      // ENABLE dropped at slot 0 bit 10: frame completes, spare word stays in the FIFO
      b = nlog[0]; p = rdc[0];
      push(0, 16'h1111); push(0, 16'h2222); push(0, 16'h5A5A);
      run_frames(0, 42, 400);
      check_eq("stop_slots", 32'(nlog[0] - b), 32'd2);
      check_eq("stop_left",  wlog[0][b],       32'h0888_8000);
      check_eq("stop_right", wlog[0][b+1],     32'h1111_0000);
      check_eq("stop_pops",  32'(rdc[0] - p),  32'd2);
      check_idle(0, "stop_idle");
      b = nlog[0];
      push(0, 16'h3333);
      run_frames(0, 42, 400);
      check_eq("restart_left",  wlog[0][b],   32'h2D2D_0000);
      check_eq("restart_right", wlog[0][b+1], 32'h1999_8000);

      // reset in slot 1 bit 5
      p = rdc[0];
      push(0, 16'h1111); push(0, 16'h2222); push(0, 16'h3333); push(0, 16'h4444);
      en[0] = 1'b1;
      cycles(150);
      check_eq("pre_rst_lrclk", 32'(lrclk[0]), 32'd1);
      rst = 1'b1;
      cycles(1);
      check_idle(0, "mid_rst");
      check_eq("mid_rst_fifo_read", 32'(fifo_read[0]), 32'd0);
      check_eq("mid_rst_underrun",  32'(underrun[0]),  32'd0);
      cycles(4);
      en[0] = 1'b0;
      check_eq("mid_rst_pops", 32'(rdc[0] - p), 32'd2);
      check_eq("mid_rst_ucnt", 32'(ucnt[0]),    32'd0);
      rst = 1'b0;
      cycles(20);
      b = nlog[0];
      run_frames(0, 42, 400);
      check_eq("post_rst_left",  wlog[0][b],   32'h1999_8000);
      check_eq("post_rst_right", wlog[0][b+1], 32'h2222_0000);
      check_eq("post_rst_ucnt",  32'(ucnt[0]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
